ex_mem_pipe: RTL

- Next-generation EX→MEM pipeline register.
- Payload widths are parametrised. Adds a valid/ready handshake, a 2-entry skid buffer (full throughput under back-pressure), synchronous flush, bubble gating of side-effect controls, and a load-use hazard detector on the held entry.
- Sits between the execute unit and the memory stage.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/pipe_skid_buf.sv | 120 ++++++++++++
 rtl/ex_mem_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: memory access size, skid-buffer state encoding and
// the EX->MEM payload layout at the default core widths.
package cpu_pkg;

    // Default core widths, used for the reference payload type below.
    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned CPU_REG_AW = 5;

    typedef enum logic [1:0] {
        MS_BYTE = 2'd0,
        MS_HALF = 2'd1,
        MS_WORD = 2'd2
    } mem_size_e;

    // Occupancy of a pipeline register with an optional skid entry.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } skid_state_e;

    // EX->MEM payload at default widths. Modules built with other widths declare
    // the same field list with their own parameters.
    typedef struct packed {
        logic [CPU_REG_AW-1:0] rd_addr;
        logic [CPU_DATA_W-1:0] rd_data;
        logic                  rd_wen;
        logic                  mem_re;
        logic                  mem_we;
        mem_size_e             mem_size;
        logic                  mem_uns;
        logic [CPU_DATA_W-1:0] st_data;
    } ex_mem_pl_t;

    // Packed width of an EX->MEM payload for arbitrary data/address widths.
    function automatic int unsigned ex_mem_pl_w(int unsigned data_w, int unsigned reg_aw);
        return reg_aw + (2 * data_w) + 6;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional 2-entry skid buffer.
// The head entry is always the older beat; flush empties the buffer and wins
// over any simultaneous accept or pop.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      r_state;
    skid_state_e      w_state_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;

    assign w_accept = in_valid_i & w_in_ready;
    assign w_pop    = w_out_valid & out_ready_i;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; flush overrides every other event.
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_next = StFull;
                    end
                end
                StFull: begin
                    // Without a skid slot accept implies pop, so FULL is kept.
                    if (w_accept && !w_pop) begin
                        w_state_next = SKID_EN ? StSkid : StFull;
                    end else if (!w_accept && w_pop) begin
                        w_state_next = StEmpty;
                    end
                end
                StSkid: begin
                    if (w_pop) begin
                        w_state_next = StFull;
                    end
                end
                default: begin
                    w_state_next = StEmpty;
                end
            endcase
        end
    end

    // Handshake outputs. With the skid slot, ready is a pure state decode so it
    // never sees out_ready_i; without it, ready passes back-pressure through.
    always_comb begin
        w_out_valid = (r_state != StEmpty);
        if (SKID_EN) begin
            w_in_ready = (r_state != StSkid);
        end else begin
            w_in_ready = !w_out_valid || out_ready_i;
        end
    end

    // Payload storage; head is replaced on accept-with-pop, refilled from skid on pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!flush_i) begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        r_head <= in_data_i;
                    end
                end
                StFull: begin
                    if (w_accept && w_pop) begin
                        r_head <= in_data_i;
                    end else if (w_accept) begin
                        r_skid <= in_data_i;
                    end
                end
                StSkid: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                    end
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_data_o  = r_head;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: packs the execute-stage controls into a payload,
// buffers it in a skid buffer, gates side-effect controls on bubbles and
// flags a load-use hazard against the ID-stage source registers.
module ex_mem_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_wen_i,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_uns_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_wen_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_uns_o,
    output logic [DATA_W-1:0] st_data_o,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic              load_use_o
);

    // Payload at this instance's widths; field order matches cpu_pkg::ex_mem_pl_t.
    typedef struct packed {
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_wen;
        logic              mem_re;
        logic              mem_we;
        mem_size_e         mem_size;
        logic              mem_uns;
        logic [DATA_W-1:0] st_data;
    } pl_t;

    localparam int unsigned PL_W = ex_mem_pl_w(DATA_W, REG_AW);

    pl_t             w_pl_in;
    pl_t             w_pl_out;
    logic [PL_W-1:0] w_pl_in_flat;
    logic [PL_W-1:0] w_pl_out_flat;
    logic            w_out_valid;
    logic            w_head_load;
    logic            w_rs_match;

    // Pack the EX-side fields into one payload word.
    always_comb begin
        w_pl_in          = '0;
        w_pl_in.rd_addr  = rd_addr_i;
        w_pl_in.rd_data  = rd_data_i;
        w_pl_in.rd_wen   = rd_wen_i;
        w_pl_in.mem_re   = mem_re_i;
        w_pl_in.mem_we   = mem_we_i;
        w_pl_in.mem_size = mem_size_e'(mem_size_i);
        w_pl_in.mem_uns  = mem_uns_i;
        w_pl_in.st_data  = st_data_i;
    end

    assign w_pl_in_flat = w_pl_in;
    assign w_pl_out     = pl_t'(w_pl_out_flat);

    pipe_skid_buf #(
        .WIDTH   (PL_W),
        .SKID_EN (SKID_EN)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (w_pl_in_flat),
        .out_valid_o (w_out_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (w_pl_out_flat)
    );

    // Head fields out; only the side-effect controls are masked on a bubble.
    always_comb begin
        out_valid_o = w_out_valid;
        rd_addr_o   = w_pl_out.rd_addr;
        rd_data_o   = w_pl_out.rd_data;
        rd_wen_o    = w_pl_out.rd_wen & w_out_valid;
        mem_re_o    = w_pl_out.mem_re & w_out_valid;
        mem_we_o    = w_pl_out.mem_we & w_out_valid;
        mem_size_o  = w_pl_out.mem_size;
        mem_uns_o   = w_pl_out.mem_uns;
        st_data_o   = w_pl_out.st_data;
    end

    // Load-use: a valid load at the head whose nonzero destination is read in ID.
    always_comb begin
        w_head_load = w_out_valid & w_pl_out.mem_re;
        w_rs_match  = (w_pl_out.rd_addr == rs1_addr_i) | (w_pl_out.rd_addr == rs2_addr_i);
        load_use_o  = w_head_load & (w_pl_out.rd_addr != '0) & w_rs_match;
    end

endmodule
